// File: rtl/universal_register_pkg.sv
// universal_register_pkg
//   Shared definitions for the universal register:
//     - operation mode encodings (MODE_HOLD .. MODE_ASHR, MODE_RSVD)
//     - auto-shift FSM state type (IDLE / RUN / FIN)
//     - is_auto_mode(): true for modes the auto-shift engine accepts
//     - step_bit():     one-step next value of a single register bit
package universal_register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } ureg_state_e;

    // Shift/rotate modes are the only ones the auto-shift engine will run.
    function automatic logic is_auto_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASHR);
    endfunction

    // Next value of one bit. lower_q is the bit that moves in on a left
    // move, upper_q the bit that moves in on a right move; at the register
    // ends the caller substitutes the serial input / wrap / sign bit.
    function automatic logic step_bit(input logic [2:0] m,
                                      input logic       d,
                                      input logic       self_q,
                                      input logic       lower_q,
                                      input logic       upper_q);
        logic r;
        case (m)
            MODE_LOAD:                       r = d;
            MODE_SHL, MODE_ROTL:             r = lower_q;
            MODE_SHR, MODE_ROTR, MODE_ASHR:  r = upper_q;
            default:                         r = self_q;  // HOLD, reserved
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ureg_step.sv
// ureg_step
//   Combinational single-step shifter: computes the register value after
//   one operation of mode_i. Shared by the single-step and auto-shift paths.
//   Ports:
//     q_i      [N]  current contents
//     d_i      [N]  parallel load data
//     mode_i   [3]  operation select
//     sin_l_i       serial bit entering MSB on logical right shift
//     sin_r_i       serial bit entering LSB on left shift
//     q_o      [N]  contents after one step
module ureg_step
    import universal_register_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] d_i,
    input  logic [2:0]   mode_i,
    input  logic         sin_l_i,
    input  logic         sin_r_i,
    output logic [N-1:0] q_o
);

    logic lsb_in;  // bit entering at LSB on a left move
    logic msb_in;  // bit entering at MSB on a right move

    always_comb begin
        lsb_in = (mode_i == MODE_ROTL) ? q_i[N-1] : sin_r_i;
        case (mode_i)
            MODE_ROTR: msb_in = q_i[0];
            MODE_ASHR: msb_in = q_i[N-1];
            default:   msb_in = sin_l_i;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic lower, upper;
        if (i == 0) begin : g_lo_end
            assign lower = lsb_in;
        end else begin : g_lo_mid
            assign lower = q_i[i-1];
        end
        if (i == N-1) begin : g_hi_end
            assign upper = msb_in;
        end else begin : g_hi_mid
            assign upper = q_i[i+1];
        end
        assign q_o[i] = step_bit(mode_i, d_i[i], q_i[i], lower, upper);
    end

endmodule

// File: rtl/universal_register.sv
// universal_register
//   N-bit register with per-cycle hold/load/shift/rotate and a multi-cycle
//   auto-shift engine (start/amt -> busy for amt cycles -> one-cycle done).
//   Optional feature macro: UREG_PARITY_EN adds a registered even-parity
//   output 'parity' (^Q), updated on the same edge as Q.
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     en              single-step enable (ignored while busy)
//     mode [3]        operation select
//     I [N]           parallel load data
//     sin_l, sin_r    serial inputs at MSB / LSB
//     start, amt      auto-shift launch and count (amt clamps to N)
//     Q [N]           registered contents
//     sout_l, sout_r  Q[N-1], Q[0]
//     busy, done      auto-shift running / one-cycle completion pulse
module universal_register
    import universal_register_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [N-1:0]     I,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [N-1:0]     Q,
`ifdef UREG_PARITY_EN
    output logic             parity,
`endif
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    ureg_state_e      state_q;
    logic [N-1:0]     q_q, q_d;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;

    logic [2:0]       step_mode;
    logic [N-1:0]     step_q;
    logic [CNT_W-1:0] amt_sat;
    logic             launch;

    assign amt_sat = (amt > CNT_W'(N)) ? CNT_W'(N) : amt;
    assign launch  = (state_q == IDLE) && start && is_auto_mode(mode);

    ureg_step #(.N(N)) u_step (
        .q_i    (q_q),
        .d_i    (I),
        .mode_i (step_mode),
        .sin_l_i(sin_l),
        .sin_r_i(sin_r),
        .q_o    (step_q)
    );

    // Next Q: RUN uses the latched mode; IDLE performs a single step when
    // start carries a non-shift mode or en is set. A launching start leaves
    // Q untouched on its own edge.
    always_comb begin
        q_d       = q_q;
        step_mode = mode;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!is_auto_mode(mode)) q_d = step_q;
                end else if (en) begin
                    q_d = step_q;
                end
            end
            RUN: begin
                step_mode = mode_q;
                q_d       = step_q;
            end
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q <= q_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (launch) begin
                        mode_q <= mode;
                        if (amt_sat == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q   <= amt_sat;
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Count of 1 means this edge applies the last shift.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UREG_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ^q_d;
    end
    assign parity = parity_q;
`endif

    assign Q      = q_q;
    assign sout_l = q_q[N-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010,
                           SHR  = 3'b011, ROTL = 3'b100, ROTR = 3'b101,
                           ASHR = 3'b110, RSVD = 3'b111;

    logic             clk = 1'b0;
    logic             reset, en, start, sin_l, sin_r;
    logic [2:0]       mode;
    logic [N-1:0]     I;
    logic [CNT_W-1:0] amt;
    logic [N-1:0]     Q;
    logic             sout_l, sout_r, busy, done;
`ifdef UREG_PARITY_EN
    logic             parity;
`endif

    universal_register #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .I     (I),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .amt   (amt),
        .Q     (Q),
`ifdef UREG_PARITY_EN
        .parity(parity),
`endif
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           cyc;
        logic [N-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every cycle the DUT presents a state; compare it against
    // the expectation queued for that cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic exp_p;
            e = sb.pop_front();
            checks++;
            exp_p = ^e.q;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not observed (now %0d)", e.name, e.cyc, cyc);
            end else if (Q !== e.q || busy !== e.busy || done !== e.done ||
                         sout_l !== e.q[N-1] || sout_r !== e.q[0]
`ifdef UREG_PARITY_EN
                         || parity !== exp_p
`endif
                        ) begin
                errors++;
                $display("FAIL %s: got Q=%h busy=%b done=%b sl=%b sr=%b, expected Q=%h busy=%b done=%b parity=%b",
                         e.name, Q, busy, done, sout_l, sout_r, e.q, e.busy, e.done, exp_p);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected state after the edge.
    task automatic cy(input string nm, input logic r, input logic e, input logic s,
                      input logic [2:0] m, input logic [N-1:0] d, input logic sl,
                      input logic sr, input logic [CNT_W-1:0] a,
                      input logic [N-1:0] eq, input logic eb, input logic ed);
        exp_t x;
        reset = r; en = e; start = s; mode = m; I = d;
        sin_l = sl; sin_r = sr; amt = a;
        x.name = nm; x.cyc = cyc + 1; x.q = eq; x.busy = eb; x.done = ed;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; mode = HOLD; I = '0;
        sin_l = 1'b0; sin_r = 1'b0; amt = '0;
        #1;
        //  name           rst en st mode  I      sl sr amt    Q      b  d
        cy("rst_init",     1, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cy("preload_a5",   0, 1, 0, LOAD, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0);
        cy("reset",        1, 1, 0, LOAD, 8'h5A, 0, 0, 4'd0, 8'h00, 0, 0);
        // single-step
        cy("load_96",      0, 1, 0, LOAD, 8'h96, 0, 0, 4'd0, 8'h96, 0, 0);
        cy("shl_sin1",     0, 1, 0, SHL,  8'h00, 0, 1, 4'd0, 8'h2D, 0, 0);
        cy("load_80",      0, 1, 0, LOAD, 8'h80, 0, 0, 4'd0, 8'h80, 0, 0);
        cy("ashr_80",      0, 1, 0, ASHR, 8'h00, 0, 0, 4'd0, 8'hC0, 0, 0);
        cy("hold_en0",     0, 0, 0, SHL,  8'h00, 0, 1, 4'd0, 8'hC0, 0, 0);
        cy("reserved",     0, 1, 0, RSVD, 8'h11, 1, 1, 4'd0, 8'hC0, 0, 0);
        cy("hold_mode",    0, 1, 0, HOLD, 8'h11, 1, 1, 4'd0, 8'hC0, 0, 0);
        cy("shr_sin1",     0, 1, 0, SHR,  8'h00, 1, 0, 4'd0, 8'hE0, 0, 0);
        cy("rotr",         0, 1, 0, ROTR, 8'h00, 0, 0, 4'd0, 8'h70, 0, 0);
        cy("rotl",         0, 1, 0, ROTL, 8'h00, 0, 0, 4'd0, 8'hE0, 0, 0);
        cy("shl_sin0",     0, 1, 0, SHL,  8'h00, 0, 0, 4'd0, 8'hC0, 0, 0);
        cy("start_load",   0, 0, 1, LOAD, 8'h5A, 0, 0, 4'd3, 8'h5A, 0, 0);
        cy("start_hold",   0, 0, 1, HOLD, 8'hFF, 0, 0, 4'd3, 8'h5A, 0, 0);
        // auto-shift ROTL by 3, en/I/start toggled while running
        cy("auto_load",    0, 1, 0, LOAD, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        cy("rotl3_start",  0, 0, 1, ROTL, 8'h00, 0, 0, 4'd3, 8'h81, 1, 0);
        cy("rotl3_run1",   0, 1, 0, LOAD, 8'hFF, 0, 0, 4'd0, 8'h03, 1, 0);
        cy("rotl3_run2",   0, 0, 1, SHR,  8'h00, 1, 1, 4'd7, 8'h06, 1, 0);
        cy("rotl3_run3",   0, 1, 0, LOAD, 8'hAA, 0, 0, 4'd0, 8'h0C, 0, 1);
        cy("rotl3_fin",    0, 0, 1, ROTL, 8'h00, 0, 0, 4'd2, 8'h0C, 0, 0);
        cy("rotl3_idle",   0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 0);
        // amt = 0: straight to FIN, Q unchanged
        cy("amt0_load",    0, 1, 0, LOAD, 8'h3C, 0, 0, 4'd0, 8'h3C, 0, 0);
        cy("amt0_start",   0, 0, 1, SHL,  8'h00, 0, 1, 4'd0, 8'h3C, 0, 1);
        cy("amt0_after",   0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h3C, 0, 0);
        // amt = 15 clamps to 8: SHR of FF with sin_l=0 empties the register
        cy("sat_load",     0, 1, 0, LOAD, 8'hFF, 0, 0, 4'd0, 8'hFF, 0, 0);
        cy("sat_start",    0, 0, 1, SHR,  8'h00, 0, 0, 4'd15, 8'hFF, 1, 0);
        for (int k = 1; k <= 7; k++)
            cy("sat_run",  0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hFF >> k, 1, 0);
        cy("sat_last",     0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 1);
        cy("sat_after",    0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        // ROTL by 8 returns the original value
        cy("rot8_load",    0, 1, 0, LOAD, 8'hB4, 0, 0, 4'd0, 8'hB4, 0, 0);
        cy("rot8_start",   0, 0, 1, ROTL, 8'h00, 0, 0, 4'd8, 8'hB4, 1, 0);
        for (int k = 1; k <= 7; k++)
            cy("rot8_run", 0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0,
               8'((16'hB4B4 << k) >> 8), 1, 0);
        cy("rot8_last",    0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hB4, 0, 1);
        cy("rot8_after",   0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'hB4, 0, 0);
        // reset in the 2nd RUN cycle aborts with no done
        cy("abort_load",   0, 1, 0, LOAD, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0);
        cy("abort_start",  0, 0, 1, ROTL, 8'h00, 0, 0, 4'd3, 8'h81, 1, 0);
        cy("abort_run1",   0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h03, 1, 0);
        cy("abort_reset",  1, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cy("abort_quiet1", 0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cy("abort_quiet2", 0, 0, 0, HOLD, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
        cy("abort_idle",   0, 1, 0, LOAD, 8'h55, 0, 0, 4'd0, 8'h55, 0, 0);
        // parity cases (parity compared only when the feature is built)
        cy("par_load07",   0, 1, 0, LOAD, 8'h07, 0, 0, 4'd0, 8'h07, 0, 0);
        cy("par_load03",   0, 1, 0, LOAD, 8'h03, 0, 0, 4'd0, 8'h03, 0, 0);
        en = 1'b0;

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
